// File: rtl/serial_nibble_rx.sv
// Framed serial nibble receiver: idle-high line, one start bit, four data bits LSB first, one stop bit.
// A good nibble is presented on data_out with a single-cycle data_valid strobe.
module serial_nibble_rx #(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [3:0] data_out,
  output logic       data_valid,
  output logic       frame_error,
  output logic       busy
);

  localparam int unsigned HALF_BIT  = CLKS_PER_BIT / 2;
  localparam logic [7:0]  HALF_LAST = 8'(HALF_BIT - 1);
  localparam logic [7:0]  BIT_LAST  = 8'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t     state, state_next;
  logic [7:0] cnt, cnt_next;
  logic [1:0] bit_idx, bit_idx_next;
  logic [3:0] shift, shift_next;
  logic [3:0] data_out_next;
  logic       data_valid_next, frame_error_next;
  logic       rx_meta, rx_s;

  // NOTE: synchronizer flops reset to 1 so the idle line never looks like a start bit after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // NOTE: every variable gets its default first so no path through the case can infer a latch.
  always_comb begin
    state_next       = state;
    cnt_next         = cnt;
    bit_idx_next     = bit_idx;
    shift_next       = shift;
    data_out_next    = data_out;
    data_valid_next  = 1'b0;
    frame_error_next = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_next = '0;
        if (!rx_s) state_next = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_next = '0;
          if (!rx_s) begin
            state_next   = DATA;
            bit_idx_next = '0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_next            = '0;
          shift_next[bit_idx] = rx_s;
          if (bit_idx == 2'd3) state_next   = STOP;
          else                 bit_idx_next = bit_idx + 2'd1;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_next   = '0;
          state_next = IDLE;
          if (rx_s) begin
            data_out_next   = shift;
            data_valid_next = 1'b1;
          end else begin
            frame_error_next = 1'b1;
          end
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      bit_idx     <= bit_idx_next;
      shift       <= shift_next;
      data_out    <= data_out_next;
      data_valid  <= data_valid_next;
      frame_error <= frame_error_next;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_nibble_rx.sv
// Directed self-checking bench for serial_nibble_rx at CLKS_PER_BIT = 8.
// rx is driven 1 time unit after a rising edge; outputs are observed on the falling edge.
module tb_serial_nibble_rx;

  localparam int CPB   = 8;
  localparam int FRAME = 6 * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [3:0] data_out;
  logic       data_valid;
  logic       frame_error;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // results of the most recent send_frame / idle call
  int         dv_count, dv_cycle, fe_count, fe_cycle, busy_count, busy_first, both_high;
  logic [3:0] dv_data;
  logic       busy_last;

  serial_nibble_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .frame_error (frame_error),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic frame_bit(input logic [3:0] d, input logic stop_bit, input int i);
    int b;
    b = i / CPB;
    if (b == 0) return 1'b0;
    if (b <= 4) return d[b-1];
    return stop_bit;
  endfunction

  task automatic clear_obs();
    dv_count = 0; dv_cycle = -1; fe_count = 0; fe_cycle = -1;
    busy_count = 0; busy_first = -1; both_high = 0; dv_data = 4'hx; busy_last = 1'bx;
  endtask

  // Observe one cycle; i is the index of the cycle within the current step.
  task automatic observe(input int i);
    @(negedge clk);
    if (data_valid) begin dv_count++; dv_cycle = i; dv_data = data_out; end
    if (frame_error) begin fe_count++; fe_cycle = i; end
    if (busy) begin busy_count++; if (busy_first < 0) busy_first = i; end
    if (data_valid && frame_error) both_high++;
    busy_last = busy;
    @(posedge clk);
    #1;
  endtask

  // Drive n cycles from a 48-cycle frame pattern (n < FRAME truncates the frame).
  task automatic send_frame(input logic [3:0] d, input logic stop_bit, input int n);
    clear_obs();
    for (int i = 0; i < n; i++) begin
      rx = frame_bit(d, stop_bit, i);
      observe(i);
    end
  endtask

  task automatic idle(input int n);
    clear_obs();
    rx = 1'b1;
    for (int i = 0; i < n; i++) observe(i);
  endtask

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data_out", data_out, 4'h0);
    check("reset_busy", busy, 1'b0);
    check("reset_strobes", {data_valid, frame_error}, 2'b00);
    reset = 1'b0;

    // Quiet line after reset release: nothing may happen.
    idle(100);
    check("idle_dv", dv_count, 0);
    check("idle_fe", fe_count, 0);
    check("idle_busy", busy_count, 0);
    check("idle_data_out", data_out, 4'h0);

    // Frame 0xA, good stop. Line falls before edge E0+1, so T = E0+3 and T+44 lands in cycle 47.
    send_frame(4'hA, 1'b1, FRAME);
    check("a_dv_count", dv_count, 1);
    check("a_dv_cycle", dv_cycle, 47);
    check("a_dv_data", dv_data, 4'hA);
    check("a_fe_count", fe_count, 0);
    check("a_busy_first", busy_first, 3);
    check("a_busy_len", busy_count, 44);
    check("a_busy_end", busy_last, 1'b0);
    idle(10);
    check("a_hold_data", data_out, 4'hA);
    check("a_no_extra_dv", dv_count, 0);

    // Frame 0x5 with a bad stop bit.
    send_frame(4'h5, 1'b0, FRAME);
    check("e_fe_count", fe_count, 1);
    check("e_fe_cycle", fe_cycle, 47);
    check("e_dv_count", dv_count, 0);
    check("e_data_out", data_out, 4'hA);
    idle(30);
    check("e_after_fe", fe_count, 0);
    check("e_after_dv", dv_count, 0);
    check("e_after_data", data_out, 4'hA);

    // Two-cycle glitch: START lasts HALF_BIT cycles, then silent return.
    clear_obs();
    for (int i = 0; i < 20; i++) begin
      rx = (i < 2) ? 1'b0 : 1'b1;
      observe(i);
    end
    check("g_busy_first", busy_first, 3);
    check("g_busy_len", busy_count, CPB / 2);
    check("g_strobes", dv_count + fe_count, 0);
    check("g_data_out", data_out, 4'hA);

    // Back-to-back 0x3 then 0xC: pulses in cycle 47 of each frame, 48 cycles apart.
    send_frame(4'h3, 1'b1, FRAME);
    check("b1_dv_count", dv_count, 1);
    check("b1_dv_cycle", dv_cycle, 47);
    check("b1_dv_data", dv_data, 4'h3);
    send_frame(4'hC, 1'b1, FRAME);
    check("b2_dv_count", dv_count, 1);
    check("b2_dv_cycle", dv_cycle, 47);
    check("b2_dv_data", dv_data, 4'hC);
    check("b2_fe_count", fe_count, 0);
    check("b2_never_both", both_high, 0);
    idle(10);
    check("b2_hold_data", data_out, 4'hC);

    // Frame 0xF aborted by reset during data bit 2 (frame cycles 24..31).
    send_frame(4'hF, 1'b1, 28);
    check("r_busy_before", busy_last, 1'b1);
    rx    = 1'b1;
    reset = 1'b1;
    #1;
    check("r_async_busy", busy, 1'b0);
    check("r_async_data", data_out, 4'h0);
    clear_obs();
    for (int i = 0; i < 5; i++) observe(i);
    check("r_during_busy", busy_count, 0);
    check("r_during_strobes", dv_count + fe_count, 0);
    check("r_during_data", data_out, 4'h0);
    reset = 1'b0;
    idle(60);
    check("r_after_strobes", dv_count + fe_count, 0);
    check("r_after_busy", busy_count, 0);
    check("r_after_data", data_out, 4'h0);
    send_frame(4'h6, 1'b1, FRAME);
    check("r6_dv_count", dv_count, 1);
    check("r6_dv_cycle", dv_cycle, 47);
    check("r6_dv_data", dv_data, 4'h6);
    idle(10);
    check("r6_hold_data", data_out, 4'h6);
    check("r6_no_extra", dv_count + fe_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_nibble_rx.md
Name: serial_nibble_rx

Overview:
- Upstream feeder for the 4-bit capture register stage.
- Receives a framed serial stream on one line: idle high, 1 start bit (0), 4 data bits LSB first, 1 stop bit (1).
- Presents the assembled nibble on data_out with a one-cycle data_valid strobe. The strobe drives the downstream register's enable directly.
- Because the downstream register clears whenever its enable is low, data_valid is a strict single-cycle pulse aligned with valid data_out.

Parameters:
- CLKS_PER_BIT, 8, clk cycles per serial bit period; legal range 4..255, even values only.
- HALF_BIT, CLKS_PER_BIT/2, derived (localparam), mid-bit sampling offset.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- rx  input  1  asynchronous serial line, idle high
- data_out  output  4  last correctly framed nibble, LSB = first received data bit
- data_valid  output  1  one-cycle strobe, data_out holds a new good nibble
- frame_error  output  1  one-cycle strobe, stop bit sampled as 0
- busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clk. All state updates on posedge clk.
- Reset values:
  - data_out = 0, data_valid = 0, frame_error = 0, busy = 0
  - state = IDLE, bit counter = 0, cycle counter = 0, shift register = 0
  - both synchronizer flops = 1 (idle line), so reset release never produces a false start
- Input sync: rx passes through a 2-flop synchronizer giving rx_s. All decisions use rx_s. Fixed latency: 2 cycles.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - cnt = 0.
  - rx_s == 0 -> START, cnt = 0. Call this edge T.
- START:
  - cnt increments each cycle.
  - At cnt == HALF_BIT-1 (edge T+HALF_BIT), sample rx_s.
  - rx_s == 0 -> DATA, cnt = 0, bit_idx = 0.
  - rx_s == 1 -> glitch: back to IDLE silently, no strobe.
- DATA:
  - At cnt == CLKS_PER_BIT-1, sample rx_s into shift[bit_idx], set cnt = 0, increment bit_idx.
  - Otherwise cnt increments.
  - Samples land at T+HALF_BIT+k*CLKS_PER_BIT for k = 1..4.
  - After bit_idx 3 is sampled -> STOP.
- STOP:
  - At cnt == CLKS_PER_BIT-1 (edge T+HALF_BIT+5*CLKS_PER_BIT), sample rx_s, then go to IDLE.
  - rx_s == 1: on that same edge, data_out <= shift and data_valid <= 1 for exactly one cycle.
  - rx_s == 0: frame_error <= 1 for one cycle; data_out unchanged; data_valid stays 0.
- data_valid and frame_error are registered, never both high, and deassert on the following edge.
- data_out changes only on a good stop bit and holds between frames.
- busy = 1 in START, DATA, STOP. busy falls on the edge that returns the FSM to IDLE.
- Back-to-back frames: a start bit may begin immediately after the stop bit period. IDLE detects it on the first cycle after the return, with half-bit margin.
- rx changing inside a bit period has no effect; only the mid-bit samples matter.
- Reset mid-frame: the frame is aborted immediately, no strobe is produced, and all values return to reset values.
- Counter width: 8 bits; bit_idx: 2 bits with no wrap beyond 3.

Test Plan:
- Reset release, rx = 1 for 100 cycles -> busy, data_valid, frame_error stay 0; data_out = 0.
- CLKS_PER_BIT = 8, frame 0xA (start 0, bits 0,1,0,1, stop 1) -> data_valid high exactly 1 cycle at T+44; data_out = 4'b1010 from that edge; frame_error = 0; busy low after T+44.
- After the 0xA frame, a frame with data 0x5 and stop bit 0 -> frame_error single pulse at T+44, data_valid stays 0, data_out remains 0xA.
- rx low for only 2 cycles (glitch) -> busy high for HALF_BIT cycles then low; no strobes; data_out unchanged.
- Back-to-back frames 0x3 then 0xC with no idle gap -> two data_valid pulses 48 cycles apart; data_out = 0x3, then 0xC.
- Reset asserted during data bit 2 of a frame 0xF, then a frame 0x6 after release -> no strobe for the aborted frame; outputs 0 during reset; second frame yields data_out = 0x6 with one data_valid pulse.
